// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants and FSM state type for the 10x10 matrix
// multiply controller and its bench.
package matrix_pkg;

   localparam int unsigned MAT_DIM    = 10;
   localparam int unsigned ADDR_WIDTH = 4;

   // Highest legal row/column/k index, at address width.
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAT_DIM - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // True when an index has reached the last row/column/k position.
   function automatic logic is_last(input logic [ADDR_WIDTH-1:0] idx);
      return (idx == LAST_IDX);
   endfunction

endpackage

// File: rtl/mat_mac.sv
// mat_mac: unsigned multiply-accumulate for one C element.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - zero the accumulator (wins over en)
//   en        - add a*b into the accumulator this cycle
//   a, b      - DATA_WIDTH unsigned operands
//   acc       - ACC_WIDTH running sum, wraps modulo 2^ACC_WIDTH
module mat_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [2*DATA_WIDTH-1:0] prod;

   assign prod = a * b;

   // Accumulator register: reset/clear zero it, en adds the full-width product.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACC_WIDTH'(prod);
      end else begin
         acc <= acc;
      end
   end

endmodule

// File: rtl/matrix_mult_ctrl.sv
// matrix_mult_ctrl: sequences C = A x B over 10x10 matrices held in external
// synchronous-read memories, one C element every 12 cycles.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   start                         - begin a multiply (seen only in IDLE)
//   busy, done                    - busy during FETCH..WRITE, done one-cycle pulse
//   a_* / b_*                     - A (i,k) and B (k,j) read ports, data one cycle late
//   c_*                           - C (i,j) write port, c_writeData = accumulated sum
module matrix_mult_ctrl
   import matrix_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  a_en_ReadMat,
   output logic                  a_en_WriteMat,
   output logic [ADDR_WIDTH-1:0] a_rowAddr,
   output logic [ADDR_WIDTH-1:0] a_colAddr,
   input  logic [DATA_WIDTH-1:0] a_readData,
   output logic                  b_en_ReadMat,
   output logic                  b_en_WriteMat,
   output logic [ADDR_WIDTH-1:0] b_rowAddr,
   output logic [ADDR_WIDTH-1:0] b_colAddr,
   input  logic [DATA_WIDTH-1:0] b_readData,
   output logic                  c_en_ReadMat,
   output logic                  c_en_WriteMat,
   output logic [ADDR_WIDTH-1:0] c_rowAddr,
   output logic [ADDR_WIDTH-1:0] c_colAddr,
   output logic [ACC_WIDTH-1:0]  c_writeData
);

   state_t                state;
   state_t                next_state;
   logic [ADDR_WIDTH-1:0] row_idx;
   logic [ADDR_WIDTH-1:0] col_idx;
   logic [ADDR_WIDTH-1:0] k_idx;
   logic                  rd_pending;   // a read was issued last cycle, data is on the bus now
   logic                  mac_clear;
   logic [ACC_WIDTH-1:0]  acc;

   assign mac_clear = ((state == ST_IDLE) && start) || (state == ST_WRITE);

   mat_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clear (mac_clear),
      .en    (rd_pending),
      .a     (a_readData),
      .b     (b_readData),
      .acc   (acc)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  next_state = start ? ST_FETCH : ST_IDLE;
         ST_FETCH: next_state = is_last(k_idx) ? ST_DRAIN : ST_FETCH;
         ST_DRAIN: next_state = ST_WRITE;
         ST_WRITE: next_state = (is_last(row_idx) && is_last(col_idx)) ? ST_DONE : ST_FETCH;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Index counters and read-pending flag; k wraps to 0 as FETCH ends so it never reaches 10.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_idx    <= '0;
         col_idx    <= '0;
         k_idx      <= '0;
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= (state == ST_FETCH);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  row_idx <= '0;
                  col_idx <= '0;
                  k_idx   <= '0;
               end else begin
                  k_idx   <= k_idx;
               end
            end
            ST_FETCH: k_idx <= is_last(k_idx) ? '0 : k_idx + ADDR_WIDTH'(1);
            ST_DRAIN: k_idx <= k_idx;
            ST_WRITE: begin
               k_idx <= '0;
               if (is_last(col_idx)) begin
                  col_idx <= '0;
                  row_idx <= is_last(row_idx) ? '0 : row_idx + ADDR_WIDTH'(1);
               end else begin
                  col_idx <= col_idx + ADDR_WIDTH'(1);
               end
            end
            ST_DONE: begin
               row_idx <= '0;
               col_idx <= '0;
               k_idx   <= '0;
            end
            default: begin
               row_idx <= '0;
               col_idx <= '0;
               k_idx   <= '0;
            end
         endcase
      end
   end

   // Output decode: everything idles at 0, each state raises only its own strobes/addresses.
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      a_en_ReadMat  = 1'b0;
      a_en_WriteMat = 1'b0;
      a_rowAddr     = '0;
      a_colAddr     = '0;
      b_en_ReadMat  = 1'b0;
      b_en_WriteMat = 1'b0;
      b_rowAddr     = '0;
      b_colAddr     = '0;
      c_en_ReadMat  = 1'b0;
      c_en_WriteMat = 1'b0;
      c_rowAddr     = '0;
      c_colAddr     = '0;
      c_writeData   = '0;
      case (state)
         ST_IDLE: busy = 1'b0;
         ST_FETCH: begin
            busy         = 1'b1;
            a_en_ReadMat = 1'b1;
            a_rowAddr    = row_idx;
            a_colAddr    = k_idx;
            b_en_ReadMat = 1'b1;
            b_rowAddr    = k_idx;
            b_colAddr    = col_idx;
         end
         ST_DRAIN: busy = 1'b1;
         ST_WRITE: begin
            busy          = 1'b1;
            c_en_WriteMat = 1'b1;
            c_rowAddr     = row_idx;
            c_colAddr     = col_idx;
            c_writeData   = acc;
         end
         ST_DONE: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// tb_matrix_mult_ctrl: directed bench for matrix_mult_ctrl. Stimulus pushes the
// expected C writes (with their cycle) and the done cycle into queues; a monitor
// on the falling edge pops and compares whenever the DUT writes C or pulses done.
module tb_matrix_mult_ctrl;
   import matrix_pkg::*;

   localparam int DW = 8;
   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done;
   logic          a_en_ReadMat, a_en_WriteMat, b_en_ReadMat, b_en_WriteMat;
   logic          c_en_ReadMat, c_en_WriteMat;
   logic [3:0]    a_rowAddr, a_colAddr, b_rowAddr, b_colAddr, c_rowAddr, c_colAddr;
   logic [DW-1:0] a_readData = '0;
   logic [DW-1:0] b_readData = '0;
   logic [AW-1:0] c_writeData;

   logic [DW-1:0] mem_a [10][10];
   logic [DW-1:0] mem_b [10][10];

   typedef struct {
      int            row;
      int            col;
      logic [AW-1:0] data;
      int            at;
   } wr_t;

   wr_t exp_wr [$];
   int  exp_done [$];
   wr_t mon_e;

   int cyc = 0;
   int t0 = 0;
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   matrix_mult_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .a_en_ReadMat  (a_en_ReadMat),
      .a_en_WriteMat (a_en_WriteMat),
      .a_rowAddr     (a_rowAddr),
      .a_colAddr     (a_colAddr),
      .a_readData    (a_readData),
      .b_en_ReadMat  (b_en_ReadMat),
      .b_en_WriteMat (b_en_WriteMat),
      .b_rowAddr     (b_rowAddr),
      .b_colAddr     (b_colAddr),
      .b_readData    (b_readData),
      .c_en_ReadMat  (c_en_ReadMat),
      .c_en_WriteMat (c_en_WriteMat),
      .c_rowAddr     (c_rowAddr),
      .c_colAddr     (c_colAddr),
      .c_writeData   (c_writeData)
   );

   // Cycle counter: cyc labels the interval following each rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory models for A and B.
   always @(posedge clk) begin
      if (a_en_ReadMat) a_readData <= mem_a[a_rowAddr][a_colAddr];
      if (b_en_ReadMat) b_readData <= mem_b[b_rowAddr][b_colAddr];
   end

   task automatic check(input string name, input longint act, input longint expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: scoreboard pops on C writes and done pulses, plus per-cycle invariants.
   always @(negedge clk) begin
      if (c_en_WriteMat) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_write", c_en_WriteMat, 0);
         end else begin
            mon_e = exp_wr.pop_front();
            check("c_row", c_rowAddr, mon_e.row);
            check("c_col", c_colAddr, mon_e.col);
            check("c_data", c_writeData, mon_e.data);
            check("c_write_cycle", cyc, mon_e.at);
         end
      end
      if (done) begin
         if (exp_done.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            check("done_cycle", cyc, exp_done.pop_front());
            check("busy_at_done", busy, 0);
         end
      end
      check("rd_wr_exclusive", (a_en_ReadMat | b_en_ReadMat) & c_en_WriteMat, 0);
      check("const_zero_en", a_en_WriteMat | b_en_WriteMat | c_en_ReadMat, 0);
      check("addr_range", (a_rowAddr > 4'd9) || (a_colAddr > 4'd9) || (b_rowAddr > 4'd9) ||
            (b_colAddr > 4'd9) || (c_rowAddr > 4'd9) || (c_colAddr > 4'd9), 0);
   end

   // mode 0: A=identity, B[r][c]=r*10+c; mode 1: all 255; mode 2: all 0
   task automatic load_mem(input int mode);
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 10; c++) begin
            case (mode)
               0: begin
                  mem_a[r][c] = (r == c) ? 8'd1 : 8'd0;
                  mem_b[r][c] = 8'(r * 10 + c);
               end
               1: begin
                  mem_a[r][c] = 8'd255;
                  mem_b[r][c] = 8'd255;
               end
               default: begin
                  mem_a[r][c] = 8'd0;
                  mem_b[r][c] = 8'd0;
               end
            endcase
         end
      end
   endtask

   // Expected element n: written 12 cycles per element after the start cycle.
   task automatic push_writes(input int mode, input int count);
      wr_t e;
      for (int n = 0; n < count; n++) begin
         e.row = n / 10;
         e.col = n % 10;
         case (mode)
            0:       e.data = 20'(n);       // identity x B gives B[r][c] = r*10+c = n
            1:       e.data = 20'd650250;   // 10 * 255 * 255
            default: e.data = 20'd0;
         endcase
         e.at = t0 + 12 + 12 * n;
         exp_wr.push_back(e);
      end
   endtask

   task automatic issue_start();
      @(posedge clk);
      #1 start = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_first_fetch", busy, 1);
      check("a_read_first_fetch", a_en_ReadMat, 1);
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain_timeout", exp_wr.size() + exp_done.size(), 0);
      repeat (4) @(posedge clk);
   endtask

   task automatic full_run(input int mode);
      load_mem(mode);
      issue_start();
      push_writes(mode, 100);
      exp_done.push_back(t0 + 1201);
      wait_empty(1400);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_enables", {a_en_ReadMat, b_en_ReadMat, c_en_WriteMat}, 0);
      check("rst_addrs", {a_rowAddr, a_colAddr, b_rowAddr, b_colAddr, c_rowAddr, c_colAddr}, 0);
      check("rst_wdata", c_writeData, 0);
      rst = 1'b0;

      full_run(0);   // identity x pattern -> C equals B
      full_run(1);   // all 255 -> 650250 everywhere

      // start re-pulsed while busy must be ignored
      load_mem(0);
      issue_start();
      push_writes(0, 100);
      exp_done.push_back(t0 + 1201);
      while (cyc < t0 + 5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (cyc < t0 + 600) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_empty(1400);

      // reset mid-run lands between the (3,5) write and the (3,6) write
      load_mem(0);
      issue_start();
      push_writes(0, 36);
      while (cyc < t0 + 440) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_enables", {a_en_ReadMat, b_en_ReadMat, c_en_WriteMat}, 0);
      check("abort_busy", busy, 0);
      repeat (1300) @(posedge clk);
      check("abort_writes_left", exp_wr.size(), 0);

      full_run(2);   // all zero -> C all zero

      // rst and start together: reset wins
      @(posedge clk);
      #1 rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      check("rst_start_busy", busy, 0);
      check("rst_start_read", a_en_ReadMat, 0);
      repeat (20) @(posedge clk);
      #1 check("rst_start_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
